// File: rtl/hex_arith_pkg.sv
// Shared encodings and widths for the hex multiplier/divider datapaths.
package hex_arith_pkg;
  localparam int DIGIT_W    = 4;
  localparam int DIVIDEND_W = 4 * DIGIT_W;
  localparam int DIVISOR_W  = 8;

  // IDLE/COMPUTE_x match the multiplier; DONE is divider-only.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPUTE_1 = 3'd1,
    COMPUTE_2 = 3'd2,
    COMPUTE_3 = 3'd3,
    COMPUTE_4 = 3'd4,
    DONE      = 3'd5
  } state_e;
endpackage

// File: rtl/hex_div_if.sv
// Request/result bundle for the sequential hex divider.
interface hex_div_if;
  import hex_arith_pkg::*;
  logic                  start;
  logic [DIVIDEND_W-1:0] in_1;
  logic [DIVISOR_W-1:0]  in_2;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;

  modport master (output start, in_1, in_2,
                  input  busy, done, div_by_zero, quotient, remainder);
  modport slave  (input  start, in_1, in_2,
                  output busy, done, div_by_zero, quotient, remainder);
endinterface

// File: rtl/hex_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module hex_div_step
  import hex_arith_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem,
  input  logic                 dvd_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_next,
  output logic                 qbit
);
  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] diff;

  always_comb begin
    trial = {rem, dvd_msb};
    diff  = trial - {1'b0, divisor};
    qbit  = (trial >= {1'b0, divisor});
    // rem < divisor on entry, so the difference always fits back in DIVISOR_W bits
    rem_next = qbit ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
  end
endmodule

// File: rtl/top_hex_divider.sv
// 16/8 sequential restoring divider: four COMPUTE states, one quotient nibble each.
module top_hex_divider
  import hex_arith_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  hex_div_if.slave bus
);
  state_e                state, state_nxt;
  logic [1:0]            cnt;
  logic [DIVIDEND_W-1:0] dvd, q_sh;
  logic [DIVISOR_W-1:0]  rem, dvs;
  logic [DIVISOR_W-1:0]  rem_nxt;
  logic                  qbit;
  logic                  busy, done_r, dbz_r;
  logic [DIVIDEND_W-1:0] quot_r;
  logic [DIVISOR_W-1:0]  rem_r;
  logic                  computing, last_step, accept;

  hex_div_step u_step (
    .rem      (rem),
    .dvd_msb  (dvd[DIVIDEND_W-1]),
    .divisor  (dvs),
    .rem_next (rem_nxt),
    .qbit     (qbit)
  );

  assign computing = (state == COMPUTE_1) || (state == COMPUTE_2) ||
                     (state == COMPUTE_3) || (state == COMPUTE_4);
  assign last_step = (state == COMPUTE_4) && (cnt == 2'd3);
  assign accept    = (state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.start) state_nxt = (bus.in_2 == '0) ? DONE : COMPUTE_1;
      COMPUTE_1: if (cnt == 2'd3) state_nxt = COMPUTE_2;
      COMPUTE_2: if (cnt == 2'd3) state_nxt = COMPUTE_3;
      COMPUTE_3: if (cnt == 2'd3) state_nxt = COMPUTE_4;
      COMPUTE_4: if (cnt == 2'd3) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Working registers shift every COMPUTE cycle; visible results load only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      dvd    <= '0;
      q_sh   <= '0;
      rem    <= '0;
      dvs    <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        if (bus.in_2 == '0) begin
          quot_r <= '1;
          rem_r  <= bus.in_1[DIVISOR_W-1:0];
          dbz_r  <= 1'b1;
          done_r <= 1'b1;
        end else begin
          dvd  <= bus.in_1;
          dvs  <= bus.in_2;
          rem  <= '0;
          q_sh <= '0;
          cnt  <= '0;
        end
      end else if (computing) begin
        rem  <= rem_nxt;
        dvd  <= {dvd[DIVIDEND_W-2:0], 1'b0};
        q_sh <= {q_sh[DIVIDEND_W-2:0], qbit};
        cnt  <= cnt + 2'd1;
        if (last_step) begin
          quot_r <= {q_sh[DIVIDEND_W-2:0], qbit};
          rem_r  <= rem_nxt;
          dbz_r  <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
endmodule

// File: tb/tb_top_hex_divider.sv
// Self-checking bench for top_hex_divider against an arithmetic (/, %) reference.
module tb_top_hex_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hex_div_if bus ();

  top_hex_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [7:0] b);
    return (b == 0) ? 16'hFFFF : 16'(a / b);
  endfunction

  function automatic logic [7:0] ref_r(input logic [15:0] a, input logic [7:0] b);
    return (b == 0) ? a[7:0] : 8'(a % b);
  endfunction

  // Drive a one-cycle start; returns at the falling edge after the sampling edge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.in_1 = a; bus.in_2 = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Cycles from start assertion until done is seen (bounded at 40).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.quotient !== 16'h0) begin errors++; $display("FAIL reset_quot got %h want 0000", bus.quotient); end
    checks++; if (bus.remainder !== 8'h0) begin errors++; $display("FAIL reset_rem got %h want 00", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_directed;
    logic [15:0] va [5] = '{16'h0A0B, 16'hFF94, 16'hFFFF, 16'h0005, 16'hABCD};
    logic [7:0]  vb [5] = '{8'h0B, 8'hFF, 8'hFF, 8'h07, 8'h01};
    logic [15:0] eq [5] = '{16'h00E9, 16'h0100, 16'h0101, 16'h0000, 16'hABCD};
    logic [7:0]  er [5] = '{8'h08, 8'h94, 8'h00, 8'h05, 8'h00};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i]);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got %b want 1", i, bus.busy); end
      wait_done(lat);
      checks++; if (lat != 17) begin errors++; $display("FAIL dir%0d_latency got %0d want 17", i, lat); end
      checks++; if (bus.quotient !== eq[i]) begin errors++; $display("FAIL dir%0d_quot got %h want %h", i, bus.quotient, eq[i]); end
      checks++; if (bus.remainder !== er[i]) begin errors++; $display("FAIL dir%0d_rem got %h want %h", i, bus.remainder, er[i]); end
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dir%0d_dbz got %b want 0", i, bus.div_by_zero); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dir%0d_after got done=%b busy=%b want 0 0", i, bus.done, bus.busy); end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    start_op(16'h1234, 8'h00);
    wait_done(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", lat); end
    checks++; if (bus.quotient !== 16'hFFFF) begin errors++; $display("FAIL dbz_quot got %h want ffff", bus.quotient); end
    checks++; if (bus.remainder !== 8'h34) begin errors++; $display("FAIL dbz_rem got %h want 34", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", bus.div_by_zero); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dbz_after got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_held got %b want 1", bus.div_by_zero); end
    start_op(16'h0064, 8'h0A);
    wait_done(lat);
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear got %b want 0", bus.div_by_zero); end
    checks++; if (bus.quotient !== 16'h000A || bus.remainder !== 8'h00) begin errors++; $display("FAIL dbz_next got %h r %h want 000a r 00", bus.quotient, bus.remainder); end
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    int busy_low = 0;
    logic [15:0] q_seen = '0;
    logic [7:0]  r_seen = '0;
    start_op(16'h7531, 8'h2D);
    repeat (4) @(negedge clk);
    bus.in_1 = 16'h0001; bus.in_2 = 8'h03; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) begin dones++; q_seen = bus.quotient; r_seen = bus.remainder; end
      else if (dones == 0 && !bus.busy) busy_low++;
      @(negedge clk);
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL busy_ignore_dones got %0d want 1", dones); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL busy_ignore_busy got %0d low cycles want 0", busy_low); end
    checks++; if (q_seen !== ref_q(16'h7531, 8'h2D) || r_seen !== ref_r(16'h7531, 8'h2D)) begin
      errors++; $display("FAIL busy_ignore_result got %h r %h want %h r %h", q_seen, r_seen, ref_q(16'h7531, 8'h2D), ref_r(16'h7531, 8'h2D));
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    start_op(16'hBEEF, 8'h13);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.quotient !== 16'h0 || bus.remainder !== 8'h0) begin errors++; $display("FAIL rst_mid_out got %h r %h want 0000 r 00", bus.quotient, bus.remainder); end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(16'hBEEF, 8'h13);
    wait_done(lat);
    checks++; if (lat != 17 || bus.quotient !== ref_q(16'hBEEF, 8'h13) || bus.remainder !== ref_r(16'hBEEF, 8'h13)) begin
      errors++; $display("FAIL rst_mid_after got lat=%0d %h r %h want 17 %h r %h", lat, bus.quotient, bus.remainder, ref_q(16'hBEEF, 8'h13), ref_r(16'hBEEF, 8'h13));
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int bad = 0;
    logic [15:0] a;
    logic [7:0]  b;
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      start_op(a, b);
      wait_done(lat);
      checks++;
      if (lat != 17 || bus.quotient !== ref_q(a, b) || bus.remainder !== ref_r(a, b) ||
          32'(bus.quotient) * 32'(b) + 32'(bus.remainder) != 32'(a) || bus.remainder >= b) begin
        errors++; bad++;
        if (bad <= 5) $display("FAIL rand%0d %h/%h got lat=%0d %h r %h want %h r %h", i, a, b, lat, bus.quotient, bus.remainder, ref_q(a, b), ref_r(a, b));
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_1 = '0; bus.in_2 = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_directed;
    test_div_zero;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
